// File: rtl/pipe_mips32.sv
// pipe_mips32: five-stage MIPS-subset core (IF/ID/EX/MEM/WB) with a unified word memory.
// Operands forward from EX/MEM and MEM/WB; branches resolve in EX; HLT retires in WB.
module pipe_mips32 #(
  parameter int MEM_WORDS = 1024
) (
  input  logic clk,
  input  logic rst_n,
  output logic halted
);
  localparam int AW = $clog2(MEM_WORDS);

  localparam logic [5:0] OP_ADD   = 6'd0;
  localparam logic [5:0] OP_SUB   = 6'd1;
  localparam logic [5:0] OP_AND   = 6'd2;
  localparam logic [5:0] OP_OR    = 6'd3;
  localparam logic [5:0] OP_SLT   = 6'd4;
  localparam logic [5:0] OP_MUL   = 6'd5;
  localparam logic [5:0] OP_LW    = 6'd8;
  localparam logic [5:0] OP_SW    = 6'd9;
  localparam logic [5:0] OP_ADDI  = 6'd10;
  localparam logic [5:0] OP_SUBI  = 6'd11;
  localparam logic [5:0] OP_SLTI  = 6'd12;
  localparam logic [5:0] OP_BNEQZ = 6'd13;
  localparam logic [5:0] OP_BEQZ  = 6'd14;
  localparam logic [5:0] OP_HLT   = 6'd63;

  logic [31:0] memory  [0:MEM_WORDS-1];
  logic [31:0] regbank [0:31];
  logic [31:0] pc;
  logic        HALTED;
  logic        TAKEN_BRANCH;
  logic        r_fetch_stop;

  logic        r_ifid_v;
  logic [31:0] r_ifid_ir, r_ifid_npc;

  logic        r_idex_v, r_idex_wr;
  logic [5:0]  r_idex_op;
  logic [4:0]  r_idex_rs, r_idex_rt, r_idex_dst;
  logic [31:0] r_idex_a, r_idex_b, r_idex_imm, r_idex_npc;

  logic        r_exmem_v, r_exmem_wr;
  logic [5:0]  r_exmem_op;
  logic [4:0]  r_exmem_dst;
  logic [31:0] r_exmem_alu, r_exmem_b;

  logic        r_memwb_v, r_memwb_wr, r_memwb_hlt;
  logic [4:0]  r_memwb_dst;
  logic [31:0] r_memwb_res;

  logic [5:0]  w_id_op;
  logic [4:0]  w_id_rs, w_id_rt, w_id_rd, w_id_dst;
  logic [31:0] w_id_imm, w_id_a, w_id_b;
  logic        w_id_wr, w_id_hlt, w_wb_we;

  logic        w_fwd_em, w_fwd_mw, w_taken, w_mem_we;
  logic [31:0] w_ex_a, w_ex_b, w_ex_alu, w_target, w_mem_rdata;

  assign halted = HALTED;

  // ---------------- ID ----------------
  assign w_id_op  = r_ifid_ir[31:26];
  assign w_id_rs  = r_ifid_ir[25:21];
  assign w_id_rt  = r_ifid_ir[20:16];
  assign w_id_rd  = r_ifid_ir[15:11];
  assign w_id_imm = {{16{r_ifid_ir[15]}}, r_ifid_ir[15:0]};
  assign w_id_hlt = r_ifid_v && (w_id_op == OP_HLT);

  assign w_wb_we = r_memwb_v && r_memwb_wr && (r_memwb_dst != 5'd0) && !HALTED;

  // Write-first: a WB write in this cycle is visible to the ID read.
  assign w_id_a = (w_wb_we && r_memwb_dst == w_id_rs) ? r_memwb_res : regbank[w_id_rs];
  assign w_id_b = (w_wb_we && r_memwb_dst == w_id_rt) ? r_memwb_res : regbank[w_id_rt];

  always_comb begin
    w_id_wr  = 1'b0;
    w_id_dst = w_id_rt;
    case (w_id_op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL: begin
        w_id_wr  = 1'b1;
        w_id_dst = w_id_rd;
      end
      OP_ADDI, OP_SUBI, OP_SLTI, OP_LW: w_id_wr = 1'b1;
      default: ;
    endcase
  end

  // ---------------- EX ----------------
  // A load in EX/MEM is not forwarded: its data only exists one stage later.
  assign w_fwd_em = r_exmem_v && r_exmem_wr && (r_exmem_op != OP_LW) && (r_exmem_dst != 5'd0);
  assign w_fwd_mw = r_memwb_v && r_memwb_wr && (r_memwb_dst != 5'd0);

  always_comb begin
    w_ex_a = r_idex_a;
    if (w_fwd_em && r_exmem_dst == r_idex_rs)      w_ex_a = r_exmem_alu;
    else if (w_fwd_mw && r_memwb_dst == r_idex_rs) w_ex_a = r_memwb_res;
    w_ex_b = r_idex_b;
    if (w_fwd_em && r_exmem_dst == r_idex_rt)      w_ex_b = r_exmem_alu;
    else if (w_fwd_mw && r_memwb_dst == r_idex_rt) w_ex_b = r_memwb_res;
  end

  always_comb begin
    w_ex_alu = 32'd0;
    case (r_idex_op)
      OP_ADD:                w_ex_alu = w_ex_a + w_ex_b;
      OP_SUB:                w_ex_alu = w_ex_a - w_ex_b;
      OP_AND:                w_ex_alu = w_ex_a & w_ex_b;
      OP_OR:                 w_ex_alu = w_ex_a | w_ex_b;
      OP_SLT:                w_ex_alu = {31'd0, $signed(w_ex_a) < $signed(w_ex_b)};
      OP_MUL:                w_ex_alu = w_ex_a * w_ex_b;
      OP_ADDI, OP_LW, OP_SW: w_ex_alu = w_ex_a + r_idex_imm;
      OP_SUBI:               w_ex_alu = w_ex_a - r_idex_imm;
      OP_SLTI:               w_ex_alu = {31'd0, $signed(w_ex_a) < $signed(r_idex_imm)};
      default: ;
    endcase
  end

  assign w_taken  = r_idex_v && (((r_idex_op == OP_BNEQZ) && (w_ex_a != 32'd0)) ||
                                 ((r_idex_op == OP_BEQZ)  && (w_ex_a == 32'd0)));
  assign w_target = r_idex_npc + r_idex_imm;

  // ---------------- MEM ----------------
  assign w_mem_rdata = memory[r_exmem_alu[AW-1:0]];
  assign w_mem_we    = r_exmem_v && (r_exmem_op == OP_SW) && !HALTED;

  // Control state: valid bits, pc and status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc           <= 32'd0;
      HALTED       <= 1'b0;
      TAKEN_BRANCH <= 1'b0;
      r_fetch_stop <= 1'b0;
      r_ifid_v     <= 1'b0;
      r_idex_v     <= 1'b0;
      r_exmem_v    <= 1'b0;
      r_memwb_v    <= 1'b0;
    end else begin
      TAKEN_BRANCH <= w_taken;
      if (r_memwb_v && r_memwb_hlt) HALTED <= 1'b1;
      if (w_taken) begin
        pc       <= w_target;
        r_ifid_v <= 1'b0;
      end else if (HALTED || r_fetch_stop || w_id_hlt) begin
        r_ifid_v <= 1'b0;
      end else begin
        pc       <= pc + 32'd1;
        r_ifid_v <= 1'b1;
      end
      if (w_id_hlt && !w_taken) r_fetch_stop <= 1'b1;
      r_idex_v  <= r_ifid_v && !w_taken;
      r_exmem_v <= r_idex_v;
      r_memwb_v <= r_exmem_v;
    end
  end

  // Pipeline payload; meaningful only while the matching valid bit is set.
  always_ff @(posedge clk) begin
    r_ifid_ir   <= memory[pc[AW-1:0]];
    r_ifid_npc  <= pc + 32'd1;
    r_idex_op   <= w_id_op;
    r_idex_rs   <= w_id_rs;
    r_idex_rt   <= w_id_rt;
    r_idex_dst  <= w_id_dst;
    r_idex_wr   <= w_id_wr;
    r_idex_a    <= w_id_a;
    r_idex_b    <= w_id_b;
    r_idex_imm  <= w_id_imm;
    r_idex_npc  <= r_ifid_npc;
    r_exmem_op  <= r_idex_op;
    r_exmem_dst <= r_idex_dst;
    r_exmem_wr  <= r_idex_wr;
    r_exmem_alu <= w_ex_alu;
    r_exmem_b   <= w_ex_b;
    r_memwb_dst <= r_exmem_dst;
    r_memwb_wr  <= r_exmem_wr;
    r_memwb_hlt <= (r_exmem_op == OP_HLT);
    r_memwb_res <= (r_exmem_op == OP_LW) ? w_mem_rdata : r_exmem_alu;
  end

  // Storage arrays are preloaded hierarchically, so they are kept out of always_ff.
  always @(posedge clk) begin
    if (w_mem_we) memory[r_exmem_alu[AW-1:0]] <= r_exmem_b;
    if (w_wb_we)  regbank[r_memwb_dst]         <= r_memwb_res;
  end
endmodule

// File: tb/tb_pipe_mips32.sv
// Bench for pipe_mips32: directed programs plus random programs checked against an
// instruction-level model (final registers, memory, branch count, halt cycle).
module tb_pipe_mips32;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic halted;

  int checks = 0;
  int failures = 0;

  logic [31:0] img_mem [0:1023];
  logic [31:0] img_reg [0:31];
  logic [31:0] m_mem   [0:1023];
  logic [31:0] m_reg   [0:31];

  localparam logic [31:0] HLT = 32'hfc000000;

  pipe_mips32 #(.MEM_WORDS(1024)) dut (.clk(clk), .rst_n(rst_n), .halted(halted));

  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input int op, input int rs, input int rt, input int rd);
    return {op[5:0], rs[4:0], rt[4:0], rd[4:0], 11'd0};
  endfunction

  function automatic logic [31:0] enc_i(input int op, input int rs, input int rt, input int imm);
    return {op[5:0], rs[4:0], rt[4:0], imm[15:0]};
  endfunction

  task automatic clear_image();
    for (int i = 0; i < 1024; i++) img_mem[i] = 32'd0;
    for (int i = 0; i < 32; i++) img_reg[i] = 32'(i);
  endtask

  task automatic wreg(input int d, input logic [31:0] v);
    if (d != 0) m_reg[d] = v;
  endtask

  // Sequential ISA semantics: one instruction at a time, no pipeline notion at all.
  task automatic model_run(output int n_exec, output int n_taken);
    int p, op, rs, rt, rd;
    logic [31:0] ir, a, b, imm;
    m_reg = img_reg;
    m_mem = img_mem;
    p = 0; n_exec = 0; n_taken = 0;
    for (int s = 0; s < 20000; s++) begin
      ir  = m_mem[p & 1023];
      op  = int'(ir[31:26]);
      rs  = int'(ir[25:21]);
      rt  = int'(ir[20:16]);
      rd  = int'(ir[15:11]);
      if (op == 63) break;
      n_exec++;
      a   = m_reg[rs];
      b   = m_reg[rt];
      imm = {{16{ir[15]}}, ir[15:0]};
      p   = p + 1;
      case (op)
        0:  wreg(rd, a + b);
        1:  wreg(rd, a - b);
        2:  wreg(rd, a & b);
        3:  wreg(rd, a | b);
        4:  wreg(rd, ($signed(a) < $signed(b)) ? 32'd1 : 32'd0);
        5:  wreg(rd, a * b);
        10: wreg(rt, a + imm);
        11: wreg(rt, a - imm);
        12: wreg(rt, ($signed(a) < $signed(imm)) ? 32'd1 : 32'd0);
        8:  wreg(rt, m_mem[int'((a + imm) & 32'h3ff)]);
        9:  m_mem[int'((a + imm) & 32'h3ff)] = b;
        13: if (a != 32'd0) begin p = p + int'($signed(imm)); n_taken++; end
        14: if (a == 32'd0) begin p = p + int'($signed(imm)); n_taken++; end
        default: ;
      endcase
    end
  endtask

  task automatic start(input bit load);
    rst_n = 1'b0;
    @(negedge clk);
    if (load) begin
      for (int i = 0; i < 1024; i++) dut.memory[i] <= img_mem[i];
      for (int i = 0; i < 32; i++) dut.regbank[i] <= img_reg[i];
    end
    @(negedge clk);
    check("rst_pc", dut.pc, 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_taken", 32'(dut.TAKEN_BRANCH), 32'd0);
    rst_n = 1'b1;
  endtask

  task automatic run_to_halt(input string nm, output int tcnt, output int cyc);
    int n_exec, n_taken;
    logic [31:0] p0;
    cyc = 0; tcnt = 0;
    while (cyc < 3000) begin
      @(posedge clk); cyc++; #1;
      if (dut.TAKEN_BRANCH === 1'b1) tcnt++;
      if (halted === 1'b1) break;
    end
    model_run(n_exec, n_taken);
    check({nm, "_halted"}, 32'(halted), 32'd1);
    check({nm, "_halt_cycle"}, 32'(cyc), 32'(n_exec + 2 * n_taken + 5));
    check({nm, "_taken_pulses"}, 32'(tcnt), 32'(n_taken));
    for (int i = 0; i < 32; i++)
      check($sformatf("%s_r%0d", nm, i), dut.regbank[i], m_reg[i]);
    for (int i = 0; i < 1024; i++)
      check($sformatf("%s_mem%0d", nm, i), dut.memory[i], m_mem[i]);
    p0 = dut.pc;
    repeat (5) @(posedge clk);
    #1;
    check({nm, "_pc_frozen"}, dut.pc, p0);
    check({nm, "_halted_stays"}, 32'(halted), 32'd1);
  endtask

  task automatic load_factorial();
    clear_image();
    img_mem[0] = enc_i(10, 0, 2, 1);
    img_mem[1] = enc_i(10, 0, 3, 5);
    img_mem[2] = enc_r(5, 2, 3, 2);
    img_mem[3] = enc_i(11, 3, 3, 1);
    img_mem[4] = enc_i(13, 3, 0, -3);
    img_mem[5] = enc_i(10, 5, 5, 1);
    img_mem[6] = enc_i(10, 6, 6, 1);
    img_mem[7] = HLT;
  endtask

  task automatic gen_random(input int n);
    int i, k, mx;
    clear_image();
    for (int r = 1; r < 31; r++)
      img_reg[r] = ($urandom_range(0, 2) == 0) ? 32'd0 : 32'($urandom);
    img_reg[31] = 32'd512;
    for (int d = 512; d < 576; d++) img_mem[d] = 32'($urandom);
    i = 0;
    while (i < n) begin
      k = $urandom_range(0, 9);
      if (k <= 3 || k == 9)
        img_mem[i] = enc_r($urandom_range(0, 5), $urandom_range(0, 15), $urandom_range(0, 15),
                           $urandom_range(0, 15));
      else if (k == 4)
        img_mem[i] = enc_i($urandom_range(10, 12), $urandom_range(0, 15), $urandom_range(0, 15),
                           int'($urandom_range(0, 65535)));
      else if (k == 5) begin
        img_mem[i] = enc_i(8, 31, $urandom_range(0, 15), $urandom_range(0, 63));
        if (i + 1 < n) begin
          i++;
          img_mem[i] = enc_i($urandom_range(15, 62), 1, 1, 1);
        end
      end else if (k == 6)
        img_mem[i] = enc_i(9, 31, $urandom_range(0, 15), $urandom_range(0, 63));
      else if (k == 7) begin
        mx = (n - (i + 1) < 3) ? n - (i + 1) : 3;
        img_mem[i] = enc_i($urandom_range(13, 14), $urandom_range(0, 15), 0, $urandom_range(0, mx));
      end else
        img_mem[i] = enc_i($urandom_range(6, 7), $urandom_range(0, 15), $urandom_range(1, 15), 5);
      i++;
    end
    img_mem[n] = HLT;
  endtask

  initial begin
    int tc, cyc, w;

    // straight-line program
    clear_image();
    img_mem[0] = 32'h2801000a; img_mem[1] = 32'h28020014; img_mem[2] = 32'h28030019;
    img_mem[3] = 32'h0ce77800; img_mem[4] = 32'h0ce77800; img_mem[5] = 32'h00222000;
    img_mem[6] = 32'h0ce77800; img_mem[7] = 32'h00832800; img_mem[8] = 32'hfc000000;
    start(1);
    run_to_halt("sl", tc, cyc);
    check("sl_R1", dut.regbank[1], 32'd10);
    check("sl_R2", dut.regbank[2], 32'd20);
    check("sl_R3", dut.regbank[3], 32'd25);
    check("sl_R4", dut.regbank[4], 32'd30);
    check("sl_R5", dut.regbank[5], 32'd55);
    check("sl_R7", dut.regbank[7], 32'd7);
    check("sl_by_cycle13", 32'(cyc <= 13), 32'd1);

    // back-to-back forwarding
    clear_image();
    img_mem[0] = enc_i(10, 0, 1, 5);
    img_mem[1] = enc_r(0, 1, 1, 2);
    img_mem[2] = enc_r(0, 2, 1, 3);
    img_mem[3] = HLT;
    start(1);
    run_to_halt("fwd", tc, cyc);
    check("fwd_R2", dut.regbank[2], 32'd10);
    check("fwd_R3", dut.regbank[3], 32'd15);

    // load / store with one spacer
    clear_image();
    img_mem[120] = 32'd85;
    img_reg[1]   = 32'd120;
    img_mem[0] = enc_i(8, 1, 2, 0);
    img_mem[1] = enc_i(10, 0, 7, 3);
    img_mem[2] = enc_i(10, 2, 2, 45);
    img_mem[3] = enc_i(9, 1, 2, 1);
    img_mem[4] = HLT;
    start(1);
    run_to_halt("ls", tc, cyc);
    check("ls_mem121", dut.memory[121], 32'd130);

    // 5! loop
    load_factorial();
    start(1);
    run_to_halt("fact", tc, cyc);
    check("fact_R2", dut.regbank[2], 32'd120);
    check("fact_R5_shadow", dut.regbank[5], 32'd6);
    check("fact_R6_shadow", dut.regbank[6], 32'd7);
    check("fact_pulses", 32'(tc), 32'd4);

    // R0 discard and freeze after halt
    clear_image();
    img_mem[0] = enc_i(10, 0, 0, 7);
    img_mem[1] = HLT;
    img_mem[2] = enc_i(10, 0, 9, 77);
    start(1);
    run_to_halt("r0", tc, cyc);
    check("r0_R0", dut.regbank[0], 32'd0);
    check("r0_R9", dut.regbank[9], 32'd9);

    // HLT in a taken-branch shadow is ignored
    clear_image();
    img_mem[0] = enc_i(14, 0, 0, 1);
    img_mem[1] = HLT;
    img_mem[2] = enc_i(10, 0, 8, 33);
    img_mem[3] = HLT;
    start(1);
    run_to_halt("bh", tc, cyc);
    check("bh_R8", dut.regbank[8], 32'd33);

    // asynchronous reset in the middle of the loop, then a clean rerun
    load_factorial();
    start(1);
    w = 0;
    while (w < 100) begin
      @(posedge clk); w++; #1;
      if (dut.TAKEN_BRANCH === 1'b1) break;
    end
    check("mrr_saw_taken", 32'(dut.TAKEN_BRANCH), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mrr_async_pc", dut.pc, 32'd0);
    check("mrr_async_HALTED", 32'(dut.HALTED), 32'd0);
    check("mrr_async_taken", 32'(dut.TAKEN_BRANCH), 32'd0);
    check("mrr_async_halted", 32'(halted), 32'd0);
    start(0);
    run_to_halt("mrr", tc, cyc);
    check("mrr_R2", dut.regbank[2], 32'd120);
    check("mrr_R5", dut.regbank[5], 32'd6);

    // random programs against the instruction-level model
    for (int t = 0; t < 8; t++) begin
      gen_random(30);
      start(1);
      run_to_halt($sformatf("rnd%0d", t), tc, cyc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
